rfphoenix_ictag_nway: RTL and testbench
=======================================

Name: rfphoenix_ictag_nway

Overview:
Parametrised N-way instruction-cache tag store. It adds per-line valid bits, registered hit detection, and victim-way selection. It also provides single-line invalidate and a sequenced invalidate-all sweep. It sits between the fetch stage, which does lookups, and the I-cache miss/fill controller, which does fills and invalidates. The fill controller consumes hit and victim results directly, so it no longer does external tag compares.

Parameters:
AWID, 32, code address width in bits.
LINES, 128, sets per way; power of 2, 2..1024.
WAYS, 4, associativity; 1..8.
OFFS, 7, line-offset bits (128-byte line).
(derived) IDXW = log2(LINES); TAGW = AWID-OFFS-IDXW; WAYW = max(1, log2(WAYS)).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
rd_en  in  1  lookup request.
rd_adr  in  AWID  lookup address.
hit  out  1  registered lookup hit.
hit_way  out  WAYW  way that hit; lowest index if several.
victim_way  out  WAYW  replacement way for the set of the last lookup.
wr  in  1  fill: write tag and set valid.
wr_adr  in  AWID  fill address.
wr_way  in  WAYW  fill way.
inv_line  in  1  invalidate any way whose tag matches inv_adr.
inv_adr  in  AWID  invalidate address.
inv_all  in  1  start invalidate-all sweep (pulse).
busy  out  1  sweep in progress.

Behaviour:
- Address split:
  - idx = adr[OFFS+IDXW-1:OFFS]
  - tag = adr[AWID-1:OFFS+IDXW]
- Storage:
  - tag RAM of WAYS*LINES x TAGW, block-RAM friendly, no reset of contents.
  - valid array of WAYS*LINES bits.
  - per-set round-robin pointer rr[idx], WAYW bits.
- Lookup, latency 1:
  - rd_en at cycle N → hit/hit_way/victim_way valid at N+1, held until the next rd_en.
  - hit = OR over ways of valid[w][idx] & (tag[w][idx]==tag).
  - victim_way = lowest-index invalid way in the set; if all ways are valid, rr[idx].
  - Read-before-write: a lookup in the same cycle as a wr to the same set sees the old contents.
- Fill:
  - wr writes tag[wr_way][idx], sets valid[wr_way][idx], and sets rr[idx] = wr_way+1, mod WAYS.
  - wr_way >= WAYS: write ignored.
- Line invalidate:
  - inv_line clears valid for every way in the set whose tag matches.
  - Applied 1 cycle after assertion; tag read at N, clear at N+1.
  - Same-cycle wr to the same set/way as the pending clear: wr wins; that way stays valid.
- Invalidate-all FSM, states IDLE and SWEEP:
  - IDLE→SWEEP on inv_all or on rst; sweep counter = 0.
  - SWEEP clears valid for all ways at index = counter, then increments the counter.
  - SWEEP→IDLE after index LINES-1 is cleared: exactly LINES cycles in SWEEP.
  - busy = (state==SWEEP).
  - While busy: hit forced to 0; wr and inv_line ignored; inv_all ignored, no restart.
- Reset:
  - rst forces state SWEEP, counter 0.
  - hit=0, hit_way=0, victim_way=0; rr all 0.
  - busy reads 1 from the first cycle after rst.
  - rst asserted mid-sweep restarts the sweep from index 0.
- WAYS=1: hit_way and victim_way are always 0.

Test Plan:
- Reset, then sweep: pulse rst 1 cycle → busy=1 for exactly 128 cycles; lookup of 0x0000_1000 afterwards gives hit=0, victim_way=0.
- Fill and hit: wr adr 0x0000_2080 way 2; rd_en same address next cycle → hit=1, hit_way=2 one cycle later. Address 0x0001_2080 (same idx, different tag) → hit=0, victim_way=0.
- Victim selection: fill all 4 ways of idx 5 in order 0,1,2,3 → victim_way=0 (rr wrapped). Fill way 0 again → victim_way=1.
- Line invalidate: after the previous fill, inv_line 0x0000_2080 → 2 cycles later lookup gives hit=0, victim_way=2.
- Same-cycle wr and pending inv_line clear on same set/way → way remains valid, lookup hits.
- inv_all with 3 sets populated → busy 128 cycles; lookups during the sweep give hit=0; all miss afterwards. rst at cycle 40 of the sweep → busy lasts 128 more cycles.

Source files
------------

// File: rtl/rfphoenix_ictag_nway_if.sv
`default_nettype none
// ============================================================================
//  Module      : rfphoenix_ictag_nway_if
//  Description : Bus bundle for the N-way I-cache tag store. It carries the
//                fetch lookup, the fill/invalidate requests and the results.
//  Revision    : 1.0  initial release
// ============================================================================
interface rfphoenix_ictag_nway_if #(
   parameter int AWID = 32,
   parameter int WAYW = 2
);
   logic            rd_en;
   logic [AWID-1:0] rd_adr;
   logic            hit;
   logic [WAYW-1:0] hit_way;
   logic [WAYW-1:0] victim_way;
   logic            wr;
   logic [AWID-1:0] wr_adr;
   logic [WAYW-1:0] wr_way;
   logic            inv_line;
   logic [AWID-1:0] inv_adr;
   logic            inv_all;
   logic            busy;

   // Requester side: fetch stage plus miss/fill controller
   modport master (
      output rd_en, rd_adr, wr, wr_adr, wr_way, inv_line, inv_adr, inv_all,
      input  hit, hit_way, victim_way, busy
   );

   // Tag store side
   modport slave (
      input  rd_en, rd_adr, wr, wr_adr, wr_way, inv_line, inv_adr, inv_all,
      output hit, hit_way, victim_way, busy
   );
endinterface
`default_nettype wire

// File: rtl/rfphoenix_ictag_nway.sv
`default_nettype none
// ============================================================================
//  Module      : rfphoenix_ictag_nway
//  Description : N-way instruction-cache tag store with per-line valid bits,
//                registered hit detection, victim selection (lowest invalid
//                way, else per-set round robin), single-line invalidate and
//                a sequenced invalidate-all sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module rfphoenix_ictag_nway #(
   parameter int AWID  = 32,
   parameter int LINES = 128,
   parameter int WAYS  = 4,
   parameter int OFFS  = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   rfphoenix_ictag_nway_if.slave bus
);
   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = AWID - OFFS - IDXW;
   localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [IDXW-1:0]  r_sweep_idx, w_sweep_idx_nxt;
   logic             w_busy;

   logic [IDXW-1:0]  w_rd_idx, w_wr_idx, w_inv_idx;
   logic [TAGW-1:0]  w_rd_tag, w_wr_tag, w_inv_tag;

   logic [WAYS-1:0]  r_valid [LINES];
   logic [WAYW-1:0]  r_rr    [LINES];
   logic [TAGW-1:0]  w_rd_way_tag  [WAYS];
   logic [TAGW-1:0]  w_inv_way_tag [WAYS];

   logic             w_way_ok, w_we;
   logic [WAYW-1:0]  w_rr_nxt;
   logic             w_hit;
   logic [WAYW-1:0]  w_hit_way, w_victim;
   logic [WAYS-1:0]  w_rd_valid, w_inv_mask;

   logic             r_hit;
   logic [WAYW-1:0]  r_hit_way, r_victim;
   logic             r_inv_pend;
   logic [IDXW-1:0]  r_inv_idx;
   logic [WAYS-1:0]  r_inv_mask;

   logic             w_unused_ok;

   assign w_rd_idx  = bus.rd_adr[OFFS+IDXW-1:OFFS];
   assign w_rd_tag  = bus.rd_adr[AWID-1:OFFS+IDXW];
   assign w_wr_idx  = bus.wr_adr[OFFS+IDXW-1:OFFS];
   assign w_wr_tag  = bus.wr_adr[AWID-1:OFFS+IDXW];
   assign w_inv_idx = bus.inv_adr[OFFS+IDXW-1:OFFS];
   assign w_inv_tag = bus.inv_adr[AWID-1:OFFS+IDXW];

   // Line-offset bits take no part in tag lookup
   assign w_unused_ok = ^{bus.rd_adr[OFFS-1:0], bus.wr_adr[OFFS-1:0], bus.inv_adr[OFFS-1:0]};

   // A fill way outside the implemented range is dropped; only possible when WAYS is not a power of 2
   if (WAYS == (1 << WAYW)) begin : g_way_pow2
      assign w_way_ok = 1'b1;
   end else begin : g_way_npow2
      assign w_way_ok = (int'(bus.wr_way) < WAYS);
   end

   assign w_we     = bus.wr & w_way_ok & ~w_busy;
   assign w_rr_nxt = (bus.wr_way == WAYW'(WAYS - 1)) ? WAYW'(0) : WAYW'(bus.wr_way + 1'b1);

   // One tag RAM per way: single write port, lookup and invalidate read ports, no reset
   for (genvar g = 0; g < WAYS; g++) begin : g_way
      logic [TAGW-1:0] r_mem [LINES];

      // Tag write on fill to this way
      always_ff @(posedge clk) begin
         if (w_we && (bus.wr_way == WAYW'(g))) begin
            r_mem[w_wr_idx] <= w_wr_tag;
         end
      end

      assign w_rd_way_tag[g]  = r_mem[w_rd_idx];
      assign w_inv_way_tag[g] = r_mem[w_inv_idx];
   end

   assign w_rd_valid = r_valid[w_rd_idx];

   // Hit (lowest matching way) and victim (lowest invalid way, else round robin)
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_victim  = r_rr[w_rd_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_rd_valid[w] && (w_rd_way_tag[w] == w_rd_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAYW'(w);
         end
         if (!w_rd_valid[w]) begin
            w_victim = WAYW'(w);
         end
      end
   end

   // Ways of the invalidate set whose stored tag matches
   always_comb begin
      w_inv_mask = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_inv_mask[w] = (w_inv_way_tag[w] == w_inv_tag);
      end
   end

   // Sweep state and index register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_SWEEP;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_idx <= w_sweep_idx_nxt;
      end
   end

   // Sweep next-state: visit every index once, then return to idle
   always_comb begin
      w_state_nxt     = r_state;
      w_sweep_idx_nxt = r_sweep_idx;
      case (r_state)
         S_IDLE: begin
            if (bus.inv_all) begin
               w_state_nxt     = S_SWEEP;
               w_sweep_idx_nxt = '0;
            end
         end
         S_SWEEP: begin
            w_sweep_idx_nxt = r_sweep_idx + 1'b1;
            if (r_sweep_idx == IDXW'(LINES - 1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_busy = (r_state == S_SWEEP);

   // Lookup result registers, held until the next lookup; hits suppressed while sweeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit     <= 1'b0;
         r_hit_way <= '0;
         r_victim  <= '0;
      end else if (bus.rd_en) begin
         r_hit     <= w_hit & ~w_busy;
         r_hit_way <= w_hit_way;
         r_victim  <= w_victim;
      end
   end

   // Capture the matching-way mask; the clear lands one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv_pend <= 1'b0;
         r_inv_idx  <= '0;
         r_inv_mask <= '0;
      end else begin
         r_inv_pend <= bus.inv_line & ~w_busy;
         r_inv_idx  <= w_inv_idx;
         r_inv_mask <= w_inv_mask;
      end
   end

   // Valid bits: sweep clear, else pending clear followed by fill set so a fill wins
   always_ff @(posedge clk) begin
      if (w_busy) begin
         r_valid[r_sweep_idx] <= '0;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            if (r_inv_pend && r_inv_mask[w]) begin
               r_valid[r_inv_idx][w] <= 1'b0;
            end
            if (w_we && (bus.wr_way == WAYW'(w))) begin
               r_valid[w_wr_idx][w] <= 1'b1;
            end
         end
      end
   end

   // Round-robin pointer: next way after the one just filled
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++) begin
            r_rr[i] <= '0;
         end
      end else if (w_we) begin
         r_rr[w_wr_idx] <= w_rr_nxt;
      end
   end

   assign bus.hit        = r_hit;
   assign bus.hit_way    = r_hit_way;
   assign bus.victim_way = r_victim;
   assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_rfphoenix_ictag_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rfphoenix_ictag_nway
//  Description : Self-checking bench for rfphoenix_ictag_nway: directed vector
//                table, multi-cycle sweep/reset sequences and random traffic
//                compared against a cache-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rfphoenix_ictag_nway;
   localparam int AWID  = 32;
   localparam int LINES = 128;
   localparam int WAYS  = 4;
   localparam int WAYW  = 2;
   localparam int OP_NOP = 0, OP_RD = 1, OP_WR = 2, OP_INV = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rfphoenix_ictag_nway_if #(.AWID(AWID), .WAYW(WAYW)) bus ();

   rfphoenix_ictag_nway #(.AWID(AWID), .LINES(LINES), .WAYS(WAYS), .OFFS(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_tag [WAYS][LINES];
   bit m_val [WAYS][LINES];
   int m_rr  [LINES];
   int m_sweep_left = 0;
   int m_sweep_idx  = 0;
   bit m_pend = 0;
   int m_pend_idx = 0;
   bit m_pend_mask [WAYS];
   bit m_hit = 0;
   int m_hit_way = 0;
   int m_vic = 0;
   bit m_vic_ok = 0;
   bit m_ready = 0;

   typedef struct {
      int          op;
      logic [31:0] adr;
      int          way;
      bit          chk;
      bit          ehit;
      int          eway;
      int          evic;
   } vec_t;
   vec_t tbl [$];

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[13:7]);
   endfunction

   function automatic int tag_of(input logic [31:0] a);
      return int'(a[31:14]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.rd_en    = 1'b0;
      bus.rd_adr   = '0;
      bus.wr       = 1'b0;
      bus.wr_adr   = '0;
      bus.wr_way   = '0;
      bus.inv_line = 1'b0;
      bus.inv_adr  = '0;
      bus.inv_all  = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic model_update();
      int  ri, rt, ii, it, wi, widx;
      bit  busy_now, found, np;
      bit  nmask [WAYS];
      if (rst) begin
         m_sweep_left = LINES;
         m_sweep_idx  = 0;
         for (int i = 0; i < LINES; i++) m_rr[i] = 0;
         m_hit = 0; m_hit_way = 0; m_vic = 0; m_vic_ok = 1;
         m_pend = 0; m_ready = 1;
         return;
      end
      busy_now = (m_sweep_left > 0);
      if (bus.rd_en) begin
         ri = idx_of(bus.rd_adr);
         rt = tag_of(bus.rd_adr);
         found = 0; m_hit_way = 0;
         for (int w = 0; w < WAYS; w++)
            if (!found && m_val[w][ri] && m_tag[w][ri] == rt) begin found = 1; m_hit_way = w; end
         m_vic = -1;
         for (int w = 0; w < WAYS; w++)
            if (m_vic < 0 && !m_val[w][ri]) m_vic = w;
         if (m_vic < 0) m_vic = m_rr[ri];
         m_hit    = found && !busy_now;
         m_vic_ok = !busy_now;
      end
      ii = idx_of(bus.inv_adr);
      it = tag_of(bus.inv_adr);
      for (int w = 0; w < WAYS; w++) nmask[w] = (m_tag[w][ii] == it);
      np = bus.inv_line && !busy_now;
      if (busy_now) begin
         for (int w = 0; w < WAYS; w++) m_val[w][m_sweep_idx] = 0;
         m_sweep_idx++;
         m_sweep_left--;
      end else begin
         if (m_pend)
            for (int w = 0; w < WAYS; w++) if (m_pend_mask[w]) m_val[w][m_pend_idx] = 0;
         if (bus.wr) begin
            wi   = int'(bus.wr_way);
            widx = idx_of(bus.wr_adr);
            m_tag[wi][widx] = tag_of(bus.wr_adr);
            m_val[wi][widx] = 1;
            m_rr[widx] = (wi + 1) % WAYS;
         end
         if (bus.inv_all) begin
            m_sweep_left = LINES;
            m_sweep_idx  = 0;
         end
      end
      m_pend      = np;
      m_pend_idx  = ii;
      m_pend_mask = nmask;
   endtask

   task automatic model_check();
      check("busy", 32'(bus.busy), 32'(m_sweep_left > 0));
      check("hit", 32'(bus.hit), 32'(m_hit));
      if (m_hit)    check("hit_way", 32'(bus.hit_way), 32'(m_hit_way));
      if (m_vic_ok) check("victim", 32'(bus.victim_way), 32'(m_vic));
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      if (m_ready) model_check();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         n++;
         step();
      end
   endtask

   task automatic add_vec(input int op, input logic [31:0] adr, input int way,
                          input bit chk, input bit ehit, input int eway, input int evic);
      vec_t v;
      v.op = op; v.adr = adr; v.way = way; v.chk = chk;
      v.ehit = ehit; v.eway = eway; v.evic = evic;
      tbl.push_back(v);
   endtask

   function automatic logic [31:0] rand_adr();
      int idxs [4] = '{0, 1, 5, 127};
      int t, i, o;
      t = int'($urandom_range(0, 3));
      i = idxs[$urandom_range(0, 3)];
      o = int'($urandom_range(0, 127));
      return 32'((t << 14) | (i << 7) | o);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int w = 0; w < WAYS; w++)
         for (int i = 0; i < LINES; i++) begin m_tag[w][i] = 0; m_val[w][i] = 0; end
      for (int w = 0; w < WAYS; w++) m_pend_mask[w] = 0;
      drive_idle();

      // Reset and the sweep it launches
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_hit", 32'(bus.hit), 0);
      check("rst_hit_way", 32'(bus.hit_way), 0);
      check("rst_victim", 32'(bus.victim_way), 0);
      check("rst_busy", 32'(bus.busy), 1);
      count_busy(n);
      check("rst_sweep_len", 32'(n), 128);

      // Directed vectors: op, address, way, check, hit, hit_way, victim
      add_vec(OP_RD,  32'h0000_1000, 0, 1, 0, 0, 0);
      add_vec(OP_WR,  32'h0000_2080, 2, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0000_2080, 0, 1, 1, 2, 0);
      add_vec(OP_RD,  32'h0001_2080, 0, 1, 0, 0, 0);
      add_vec(OP_WR,  32'h0000_4280, 0, 0, 0, 0, 0);
      add_vec(OP_WR,  32'h0000_8280, 1, 0, 0, 0, 0);
      add_vec(OP_WR,  32'h0000_C280, 2, 0, 0, 0, 0);
      add_vec(OP_WR,  32'h0001_0280, 3, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0000_4280, 0, 1, 1, 0, 0);
      add_vec(OP_RD,  32'h0000_C280, 0, 1, 1, 2, 0);
      add_vec(OP_WR,  32'h0001_4280, 0, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0001_4280, 0, 1, 1, 0, 1);
      add_vec(OP_RD,  32'h0000_4280, 0, 1, 0, 0, 1);
      add_vec(OP_WR,  32'h0002_2080, 0, 0, 0, 0, 0);
      add_vec(OP_WR,  32'h0002_6080, 1, 0, 0, 0, 0);
      add_vec(OP_INV, 32'h0000_2080, 0, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0000_2080, 0, 1, 1, 2, 3);
      add_vec(OP_RD,  32'h0000_2080, 0, 1, 0, 0, 2);
      add_vec(OP_RD,  32'h0002_6080, 0, 1, 1, 1, 2);
      add_vec(OP_INV, 32'h0002_2080, 0, 0, 0, 0, 0);
      add_vec(OP_WR,  32'h0002_2080, 0, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0002_2080, 0, 1, 1, 0, 2);
      add_vec(OP_WR,  32'h0000_1000, 1, 0, 0, 0, 0);
      add_vec(OP_RD,  32'h0000_1000, 0, 1, 1, 1, 0);

      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_RD:  begin bus.rd_en = 1'b1; bus.rd_adr = tbl[i].adr; end
            OP_WR:  begin bus.wr = 1'b1; bus.wr_adr = tbl[i].adr; bus.wr_way = WAYW'(tbl[i].way); end
            OP_INV: begin bus.inv_line = 1'b1; bus.inv_adr = tbl[i].adr; end
            default: ;
         endcase
         step();
         drive_idle();
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d_hit", i), 32'(bus.hit), 32'(tbl[i].ehit));
            if (tbl[i].ehit) check($sformatf("tbl%0d_hit_way", i), 32'(bus.hit_way), 32'(tbl[i].eway));
            check($sformatf("tbl%0d_victim", i), 32'(bus.victim_way), 32'(tbl[i].evic));
         end
      end

      // Invalidate-all with sets 5, 32 and 65 populated; lookups during the sweep must miss
      bus.inv_all = 1'b1;
      step();
      drive_idle();
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         bit rd;
         rd = (n % 16 == 3);
         bus.rd_en  = rd;
         bus.rd_adr = 32'h0001_4280;
         step();
         drive_idle();
         if (rd) check("sweep_hit", 32'(bus.hit), 0);
         n++;
      end
      check("inv_all_len", 32'(n), 128);
      begin
         logic [31:0] post [3];
         post[0] = 32'h0001_4280; post[1] = 32'h0000_1000; post[2] = 32'h0002_2080;
         foreach (post[k]) begin
            bus.rd_en = 1'b1; bus.rd_adr = post[k];
            step();
            drive_idle();
            check($sformatf("post_sweep%0d_hit", k), 32'(bus.hit), 0);
            check($sformatf("post_sweep%0d_victim", k), 32'(bus.victim_way), 0);
         end
      end

      // Reset 40 cycles into a sweep restarts it from index 0
      bus.inv_all = 1'b1;
      step();
      drive_idle();
      repeat (39) step();
      check("mid_sweep_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      count_busy(n);
      check("rst_mid_sweep_len", 32'(n), 128);

      // Random traffic against the model
      repeat (2500) begin
         bus.rd_en    = ($urandom_range(0, 1) == 1);
         bus.rd_adr   = rand_adr();
         bus.wr       = ($urandom_range(0, 9) < 3);
         bus.wr_adr   = rand_adr();
         bus.wr_way   = WAYW'($urandom_range(0, WAYS - 1));
         bus.inv_line = ($urandom_range(0, 9) == 0);
         bus.inv_adr  = rand_adr();
         bus.inv_all  = ($urandom_range(0, 999) < 3);
         rst          = ($urandom_range(0, 999) == 0);
         step();
         rst = 1'b0;
         drive_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
